// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants and FSM encoding for the SD sector buffer
package sd_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int IDX_W        = 9;
  localparam int LBA_W        = 23;
  localparam int CNT_W        = IDX_W + 1;

  // Byte count that marks a complete sector transfer
  localparam logic [CNT_W-1:0] SECTOR_CNT = CNT_W'(SECTOR_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_RD,
    ST_READING,
    ST_REQ_WR,
    ST_WRITING,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/sd_sector_ram.sv
// rtl/sd_sector_ram.sv - 512x8 sector RAM, one write port, one registered read port
module sd_sector_ram
  import sd_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [SECTOR_BYTES];

  // Array write; contents are left unreset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; the output register resets so both readers start at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata <= '0;
    else          rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_sector_buffer.sv
// rtl/sd_sector_buffer.sv - sector staging buffer for the SPI SD controller; watchdog via SD_SECTOR_BUF_WDOG_EN
module sd_sector_buffer
  import sd_pkg::*;
#(
  parameter int WDOG_CYCLES = 25_000_000
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_load,
  input  logic             cmd_store,
  input  logic [LBA_W-1:0] cmd_lba,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [IDX_W-1:0] usr_addr,
  input  logic             usr_we,
  input  logic [7:0]       usr_wdata,
  output logic [7:0]       usr_rdata,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic [31:0]      sd_address,
  input  logic [7:0]       sd_dout,
  input  logic             sd_byte_avail,
  output logic [7:0]       sd_din,
  input  logic             sd_rfnb,
  input  logic             sd_ready
);

  state_t           state;
  logic [CNT_W-1:0] cnt;          // bytes moved; 512 means a full sector
  logic             avail_q;
  logic             rfnb_q;
  logic             seen_ready;   // sd_ready high observed during REQ_*
  logic             marker_seen;  // command-phase rfnb edge already consumed
  logic             over;         // more than a sector of rfnb edges on a store

  logic             avail_rise;
  logic             rfnb_fall;
  logic             usr_side;
  logic [IDX_W-1:0] ptr;
  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [7:0]       ram_wdata;
  logic [IDX_W-1:0] ram_raddr;
  logic [7:0]       ram_rdata;

  assign avail_rise = sd_byte_avail & ~avail_q;
  assign rfnb_fall  = rfnb_q & ~sd_rfnb;
  assign usr_side   = (state == ST_IDLE) || (state == ST_FINISH);
  assign ptr        = cnt[CNT_W-1] ? {IDX_W{1'b1}} : cnt[IDX_W-1:0];

  assign ram_we    = usr_side ? usr_we    : ((state == ST_READING) && avail_rise && !cnt[CNT_W-1]);
  assign ram_waddr = usr_side ? usr_addr  : ptr;
  assign ram_wdata = usr_side ? usr_wdata : sd_dout;
  assign ram_raddr = ((state == ST_REQ_WR) || (state == ST_WRITING)) ? ptr : usr_addr;

  assign usr_rdata = ram_rdata;
  assign sd_din    = ram_rdata;

  sd_sector_ram u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr   (ram_raddr),
    .rdata   (ram_rdata)
  );

`ifdef SD_SECTOR_BUF_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;
  logic            byte_counted;
  logic            wdog_active;
  assign byte_counted = ((state == ST_READING) && avail_rise) ||
                        ((state == ST_WRITING) && rfnb_fall && marker_seen);
  assign wdog_active  = (state == ST_REQ_RD) || (state == ST_READING) ||
                        (state == ST_REQ_WR) || (state == ST_WRITING);
`endif

  // Transfer sequencer: command accept, strobe handshake, byte counting, completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      sd_address  <= '0;
      cnt         <= '0;
      avail_q     <= 1'b0;
      rfnb_q      <= 1'b0;
      seen_ready  <= 1'b0;
      marker_seen <= 1'b0;
      over        <= 1'b0;
`ifdef SD_SECTOR_BUF_WDOG_EN
      wdog_cnt    <= '0;
`endif
    end else begin
      avail_q <= sd_byte_avail;
      rfnb_q  <= sd_rfnb;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_load || cmd_store) begin
            sd_address  <= {cmd_lba, {IDX_W{1'b0}}};
            cnt         <= '0;
            err         <= 1'b0;
            busy        <= 1'b1;
            seen_ready  <= 1'b0;
            marker_seen <= 1'b0;
            over        <= 1'b0;
            if (cmd_load) begin
              state <= ST_REQ_RD;
              sd_rd <= 1'b1;
            end else begin
              state <= ST_REQ_WR;
              sd_wr <= 1'b1;
            end
          end
        end
        ST_REQ_RD: begin
          if (sd_ready) seen_ready <= 1'b1;
          else if (seen_ready) begin
            sd_rd <= 1'b0;
            state <= ST_READING;
          end
        end
        ST_REQ_WR: begin
          if (sd_ready) seen_ready <= 1'b1;
          else if (seen_ready) begin
            sd_wr <= 1'b0;
            state <= ST_WRITING;
          end
        end
        ST_READING: begin
          if (avail_rise && !cnt[CNT_W-1]) cnt <= cnt + 1'b1;
          if (sd_ready) begin
            state <= ST_FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
            err   <= (cnt != SECTOR_CNT);
          end
        end
        ST_WRITING: begin
          if (rfnb_fall) begin
            if (!marker_seen)         marker_seen <= 1'b1;
            else if (!cnt[CNT_W-1])   cnt <= cnt + 1'b1;
            else                      over <= 1'b1;
          end
          if (sd_ready) begin
            state <= ST_FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
            err   <= (cnt != SECTOR_CNT) || over;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
`ifdef SD_SECTOR_BUF_WDOG_EN
      // A stalled controller aborts the transfer; these assignments override the case above
      if (!wdog_active || byte_counted) begin
        wdog_cnt <= '0;
      end else if (wdog_cnt == WD_W'(WDOG_CYCLES - 1)) begin
        wdog_cnt <= '0;
        err      <= 1'b1;
        sd_rd    <= 1'b0;
        sd_wr    <= 1'b0;
        done     <= 1'b1;
        busy     <= 1'b0;
        state    <= ST_FINISH;
      end else begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
`endif
    end
  end

endmodule
